// File: rtl/dw_pkg.sv
// Shared types and default sizes for the depthwise result drain path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dw_pkg;

   // Frame sequencing states of the drain controller.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DRAIN   = 2'd2
   } dw_state_e;

   // Default array geometry: one result word per kcell, kcells per column.
   localparam int DW_OUT_DATA_WIDTH = 32;
   localparam int DW_NUM_KCELLS     = 3;

   // One captured column: all kcell words side by side, kcell 0 in the MS slice.
   localparam int DW_ENTRY_WIDTH = DW_NUM_KCELLS * DW_OUT_DATA_WIDTH;

endpackage

// File: rtl/dw_result_fifo.sv
// Column buffer: synchronous FIFO whose head entry sits in a registered output.
// Latency: a write into an empty FIFO is visible at rd_data on the next cycle.
// Backpressure: writes are refused when full unless a read frees a slot in the same cycle.
module dw_result_fifo
   import dw_pkg::*;
#(
   parameter int WIDTH = DW_ENTRY_WIDTH,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
   localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_rd;
   logic             do_wr;

   // rd_data always mirrors the oldest entry, so a read retires it and
   // exposes the next one in the same edge.
   assign empty = (count == '0);
   assign full  = (count == CNT_MAX);
   assign do_rd = rd_en & ~empty;
   assign do_wr = wr_en & (~full | do_rd);

   // Storage array; left unreset so it can map onto plain register/RAM cells.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers, occupancy and the registered head entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         rd_data <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({do_wr, do_rd})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         // Next head: the entry behind the current one, or the incoming
         // write when it becomes the only entry.
         if (do_rd) begin
            if (count == CNT_ONE) begin
               if (do_wr) begin
                  rd_data <= wr_data;
               end
            end else begin
               rd_data <= mem[rd_ptr + PTR_ONE];
            end
         end else if (empty && do_wr) begin
            rd_data <= wr_data;
         end
      end
   end

endmodule

// File: rtl/dw_result_drain.sv
// Captures depthwise-array result columns and serialises them into one word per handshake.
// Latency: act_valid at t -> capture at t+PIPE_LAT -> first out_valid at t+PIPE_LAT+1.
// Backpressure: out_ready stalls the serialiser; FIFO absorbs columns, overflowing ones are dropped.
// Optional build macro DW_DRAIN_RELU_EN: clamp negative output words to zero.
module dw_result_drain
   import dw_pkg::*;
#(
   parameter int OUT_DATA_WIDTH = DW_OUT_DATA_WIDTH,
   parameter int NUM_KCELLS     = DW_NUM_KCELLS,
   parameter int PIPE_LAT       = 4,
   parameter int FIFO_DEPTH     = 8,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic [CNT_WIDTH-1:0]                 num_cols,
   input  logic                                 act_valid,
   input  logic [NUM_KCELLS*OUT_DATA_WIDTH-1:0] result,
   output logic [OUT_DATA_WIDTH-1:0]            out_data,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic                                 out_last,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 overflow
);

   localparam int ENTRY_W = NUM_KCELLS * OUT_DATA_WIDTH;
   localparam int IDX_W   = (NUM_KCELLS > 1) ? $clog2(NUM_KCELLS) : 1;
   localparam int FCNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_KCELLS - 1);
   localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);
   localparam logic [CNT_WIDTH-1:0] COL_ONE  = CNT_WIDTH'(1);
   localparam logic [FCNT_W-1:0]    FCNT_ONE = FCNT_W'(1);

   dw_state_e              state;
   dw_state_e              state_nxt;
   logic                   finish;
   logic [PIPE_LAT-1:0]    vld_pipe;
   logic                   res_valid;
   logic [CNT_WIDTH-1:0]   num_cols_q;
   logic [CNT_WIDTH-1:0]   col_cnt;
   logic                   last_stored;
   logic                   ovf_q;
   logic                   done_q;
   logic                   capture;
   logic                   cap_last_col;
   logic                   drop;
   logic                   fifo_empty;
   logic                   fifo_full;
   logic [FCNT_W-1:0]      fifo_count;
   logic [ENTRY_W-1:0]     head;
   logic [IDX_W-1:0]       idx;
   logic                   word_last;
   logic                   hs;
   logic                   pop;
   logic [OUT_DATA_WIDTH-1:0] word;

   // Result column is valid PIPE_LAT cycles after its activation strobe.
   assign res_valid = vld_pipe[PIPE_LAT-1];

   // Columns are only taken while collecting; a full FIFO drops the column
   // unless the serialiser retires the head entry in the same cycle.
   assign capture      = (state == COLLECT) & res_valid;
   assign cap_last_col = capture & (col_cnt == num_cols_q - COL_ONE);
   assign drop         = capture & fifo_full & ~pop;

   // The FIFO head register is the serialiser's current entry; idx walks
   // its words, and the entry is retired when its last word is accepted.
   assign out_valid = ~fifo_empty;
   assign word_last = (idx == LAST_IDX);
   assign hs        = out_valid & out_ready;
   assign pop       = hs & word_last;

   // The frame's final column, when kept, is always the newest entry, so it
   // is the last word of the sole remaining entry once collection is over.
   assign out_last = out_valid & word_last & (fifo_count == FCNT_ONE)
                   & (state == DRAIN) & last_stored;

   assign busy     = (state != IDLE);
   assign done     = done_q;
   assign overflow = ovf_q;

   dw_result_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (capture),
      .wr_data (result),
      .rd_en   (pop),
      .rd_data (head),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .count   (fifo_count)
   );

   // Pick the current word from the head entry, kcell 0 (MS slice) first.
   always_comb begin
      word = '0;
      for (int k = 0; k < NUM_KCELLS; k++) begin
         if (idx == IDX_W'(k)) begin
            word = head[(NUM_KCELLS-1-k)*OUT_DATA_WIDTH +: OUT_DATA_WIDTH];
         end
      end
   end

`ifdef DW_DRAIN_RELU_EN
   assign out_data = (out_valid & ~word[OUT_DATA_WIDTH-1]) ? word : '0;
`else
   assign out_data = out_valid ? word : '0;
`endif

   // Next-state and frame-completion decode.
   always_comb begin
      state_nxt = state;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (num_cols == '0) begin
                  finish = 1'b1;
               end else begin
                  state_nxt = COLLECT;
               end
            end
         end
         COLLECT: begin
            if (cap_last_col) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            // A dropped final column never produces out_last, so finish on empty.
            if ((hs & out_last) | (fifo_empty & ~last_stored)) begin
               state_nxt = IDLE;
               finish    = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register and registered done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_q <= finish;
      end
   end

   // Activation-valid delay line, running in every state.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[0] <= act_valid;
         for (int i = 1; i < PIPE_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
         end
      end
   end

   // Per-frame bookkeeping: column count, final-column tracking, sticky overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         num_cols_q  <= '0;
         col_cnt     <= '0;
         last_stored <= 1'b0;
         ovf_q       <= 1'b0;
      end else if ((state == IDLE) && start) begin
         num_cols_q  <= num_cols;
         col_cnt     <= '0;
         last_stored <= 1'b0;
         ovf_q       <= 1'b0;
      end else if (capture) begin
         col_cnt <= col_cnt + COL_ONE;
         if (drop) begin
            ovf_q <= 1'b1;
         end
         if (cap_last_col && !drop) begin
            last_stored <= 1'b1;
         end
      end
   end

   // Word index within the head entry; advances only on handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx <= '0;
      end else if (hs) begin
         idx <= word_last ? '0 : idx + IDX_ONE;
      end
   end

endmodule

// File: tb/tb_dw_result_drain.sv
// Directed bench for dw_result_drain: frames, backpressure, overflow, empty frame, reset, ReLU.
// Latency: expected cycle numbers are counted from the cycle after start.
// Backpressure: out_ready is driven per scenario (always, alternating, held low then released).
module tb_dw_result_drain;

   localparam int W    = 32;
   localparam int NK   = 3;
   localparam int PIPE = 4;

   logic            clk;
   logic            reset;
   logic            start;
   logic [15:0]     num_cols;
   logic            act_valid;
   logic [NK*W-1:0] result;
   logic [W-1:0]    out_data;
   logic            out_valid;
   logic            out_ready;
   logic            out_last;
   logic            busy;
   logic            done;
   logic            overflow;

   int checks = 0;
   int errors = 0;

   logic [NK*W-1:0] col_tab [16];
   logic [31:0]     got_w [$];
   int              got_last [$];
   int              first_vld;
   int              done_cyc;
   int              mid_c;
   logic            mid_ovf;
   logic            mid_busy;

   dw_result_drain #(
      .OUT_DATA_WIDTH (W),
      .NUM_KCELLS     (NK),
      .PIPE_LAT       (PIPE),
      .FIFO_DEPTH     (8),
      .CNT_WIDTH      (16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .num_cols  (num_cols),
      .act_valid (act_valid),
      .result    (result),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      act_valid = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   // Run one frame; cycle 0 is the cycle after start. rmode: 0 ready always,
   // 1 ready on odd cycles, 2 ready from cycle rel onwards.
   task automatic run_frame(input logic [15:0] n, input logic [63:0] av,
                            input int rmode, input int rel, input int maxc);
      int         col;
      logic       prev_stall;
      logic [31:0] prev_dat;
      bit         seen;
      got_w.delete();
      got_last.delete();
      first_vld  = -1;
      done_cyc   = -1;
      col        = 0;
      prev_stall = 1'b0;
      prev_dat   = '0;
      seen       = 1'b0;
      start      = 1'b1;
      num_cols   = n;
      step();
      start = 1'b0;
      for (int c = 0; c < maxc && !seen; c++) begin
         act_valid = (c < 64) ? av[c] : 1'b0;
         if (c >= PIPE && (c - PIPE) < 64 && av[c-PIPE] && col < 16) begin
            result = col_tab[col];
            col++;
         end else begin
            result = {NK{32'hBADBAD00}};
         end
         case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((c % 2) == 1);
            default: out_ready = (c >= rel);
         endcase
         if (prev_stall) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, prev_dat);
         end
         if (c == mid_c) begin
            mid_ovf  = overflow;
            mid_busy = busy;
         end
         if (done) begin
            seen     = 1'b1;
            done_cyc = c;
            check("busy_at_done", busy, 0);
         end else begin
            if (out_valid && first_vld < 0) first_vld = c;
            if (out_valid && out_ready) begin
               got_w.push_back(out_data);
               if (out_last) got_last.push_back(got_w.size() - 1);
            end
            prev_stall = out_valid & ~out_ready;
            prev_dat   = out_data;
            step();
         end
      end
      act_valid = 1'b0;
      out_ready = 1'b0;
      if (!seen) check("done_timeout", 0, 1);
   endtask

   task automatic check_small_frame(input string tag, input int exp_done);
      logic [31:0] exp_w [6];
      exp_w = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd7};
      check({tag, "_nwords"}, got_w.size(), 6);
      for (int i = 0; i < 6 && i < got_w.size(); i++) check({tag, "_word"}, got_w[i], exp_w[i]);
      check({tag, "_first_vld"}, first_vld, 5);
      check({tag, "_nlast"}, got_last.size(), 1);
      if (got_last.size() > 0) check({tag, "_last_pos"}, got_last[0], 5);
      check({tag, "_done_cyc"}, done_cyc, exp_done);
      check({tag, "_overflow"}, overflow, 0);
   endtask

   initial begin
      bit any_vld, any_busy, extra_done;
      reset     = 1'b1;
      start     = 1'b0;
      num_cols  = '0;
      act_valid = 1'b0;
      result    = '0;
      out_ready = 1'b0;
      mid_c     = -1;
      mid_ovf   = 1'b0;
      mid_busy  = 1'b0;
      step(); step(); step();

      // Reset values
      check("rst_out_data", out_data, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_overflow", overflow, 0);
      reset = 1'b0;
      step();

      // Two-column frame, out_ready high
      col_tab[0] = {32'd1, 32'd2, 32'd3};
      col_tab[1] = {32'd4, 32'd5, 32'd7};
      run_frame(16'd2, 64'b1001, 0, 0, 60);
      check_small_frame("t1", 11);
      idle(6);

      // Same frame, out_ready alternating
      run_frame(16'd2, 64'b1001, 1, 0, 60);
      check_small_frame("t2", 16);
      idle(6);

      // Overflow: 12 back-to-back columns, out_ready low until cycle 30
      for (int j = 0; j < 12; j++)
         col_tab[j] = {32'(j*16 + 1), 32'(j*16 + 2), 32'(j*16 + 3)};
      mid_c = 20;
      run_frame(16'd12, 64'hFFF, 2, 30, 120);
      mid_c = -1;
      check("t3_mid_overflow", mid_ovf, 1);
      check("t3_mid_busy", mid_busy, 1);
      check("t3_nwords", got_w.size(), 24);
      for (int i = 0; i < 24 && i < got_w.size(); i++)
         check("t3_word", got_w[i], 32'((i / 3) * 16 + (i % 3) + 1));
      check("t3_nlast", got_last.size(), 0);
      check("t3_done_cyc", done_cyc, 55);
      check("t3_overflow_end", overflow, 1);
      idle(6);

      // Empty frame
      start    = 1'b1;
      num_cols = 16'd0;
      step();
      start = 1'b0;
      check("t4_done", done, 1);
      check("t4_busy", busy, 0);
      check("t4_overflow_cleared", overflow, 0);
      any_vld = 0; any_busy = 0; extra_done = 0;
      for (int c = 1; c < 8; c++) begin
         step();
         any_vld    |= out_valid;
         any_busy   |= busy;
         extra_done |= done;
      end
      check("t4_no_valid", any_vld, 0);
      check("t4_no_busy", any_busy, 0);
      check("t4_single_done", extra_done, 0);
      idle(4);

      // Reset mid-DRAIN with four entries buffered
      start    = 1'b1;
      num_cols = 16'd4;
      step();
      start = 1'b0;
      for (int c = 0; c <= 10; c++) begin
         act_valid = (c < 4);
         result    = (c >= PIPE && c < PIPE + 4) ? col_tab[c-PIPE] : {NK{32'hBADBAD00}};
         out_ready = 1'b0;
         if (c < 10) step();
      end
      check("t5_pre_busy", busy, 1);
      check("t5_pre_valid", out_valid, 1);
      check("t5_pre_data", out_data, 1);
      reset = 1'b1;
      step();
      check("t5_rst_out_data", out_data, 0);
      check("t5_rst_out_valid", out_valid, 0);
      check("t5_rst_out_last", out_last, 0);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_done", done, 0);
      check("t5_rst_overflow", overflow, 0);
      reset = 1'b0;
      idle(3);
      col_tab[0] = {32'd1, 32'd2, 32'd3};
      col_tab[1] = {32'd4, 32'd5, 32'd7};
      run_frame(16'd2, 64'b1001, 0, 0, 60);
      check_small_frame("t5_after", 11);
      idle(6);

      // Negative / zero / positive words (ReLU when enabled)
      col_tab[0] = {32'hFFFF_FFFB, 32'h0, 32'd9};
      run_frame(16'd1, 64'b1, 0, 0, 60);
      check("t6_nwords", got_w.size(), 3);
`ifdef DW_DRAIN_RELU_EN
      if (got_w.size() > 0) check("t6_word0", got_w[0], 32'h0);
`else
      if (got_w.size() > 0) check("t6_word0", got_w[0], 32'hFFFF_FFFB);
`endif
      if (got_w.size() > 1) check("t6_word1", got_w[1], 32'h0);
      if (got_w.size() > 2) check("t6_word2", got_w[2], 32'd9);
      check("t6_nlast", got_last.size(), 1);
      check("t6_done_cyc", done_cyc, 8);
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
